hs_ram_arbiter: RTL and testbench
=================================

Name: hs_ram_arbiter

Overview:
- Shares the game CPU's work-RAM port between the Z80 game CPU and the hiscore save/restore engine.
- On a hiscore access request: asks the pause block to halt the CPU, waits for the pause acknowledge plus a settle delay, then hands the RAM port to the hiscore engine. On release, drains outstanding accesses before unpausing.
- Sits between the hiscore module, the pause module and the game core's RAM, in the `clk_sys` domain.

Parameters:
- AW, 16, RAM address width.
- SETTLE_CYC, 4, cycles to wait after `paused` before granting (CPU bus quiesce).
- RELEASE_CYC, 2, cycles `pause_req` is held after grant drops; must be >= RD_LAT.
- RD_LAT, 1, RAM read latency in cycles.
- TIMEOUT_CYC, 65535, pause-acknowledge watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock (`clk_sys`).
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  AW  CPU RAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_rdata  out  8  RAM read data to CPU (= `ram_rdata`).
- hs_req  in  1  hiscore access intent, level; held for the whole transfer.
- hs_addr  in  AW  hiscore RAM address.
- hs_wdata  in  8  hiscore write data.
- hs_we  in  1  hiscore write strobe.
- hs_rd  in  1  hiscore read strobe.
- hs_gnt  out  1  RAM port owned by hiscore.
- hs_rdata  out  8  read data (= `ram_rdata`).
- hs_rvalid  out  1  `hs_rdata` valid, RD_LAT cycles after a granted `hs_rd`.
- pause_req  out  1  request CPU halt (to the pause block).
- paused  in  1  CPU halted acknowledge.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data.
- arb_timeout  out  1  watchdog pulse; tied 0 without the optional feature.

Behaviour:
- Mux select is registered `hs_gnt`.
  - `hs_gnt`=0: `ram_addr`/`ram_wdata`=cpu_*, `ram_we`=`cpu_we`.
  - `hs_gnt`=1: `ram_addr`/`ram_wdata`=hs_*, `ram_we`=`hs_we`; `cpu_we` is blocked.
- `hs_we`/`hs_rd` while `hs_gnt`=0 are ignored: no RAM write, no `hs_rvalid`.
- `hs_rvalid`: RD_LAT-deep shift register fed with `hs_gnt & hs_rd`.
- Reset: state IDLE; `pause_req`, `hs_gnt`, `hs_rvalid`, `arb_timeout`=0; counters and rvalid pipe cleared. Reset mid-grant returns the port to the CPU on the next cycle with no drain.
- State machine (all transitions on `clk` edge):
  - IDLE: `hs_req`=1 → PAUSE_WAIT, `pause_req`<=1.
  - PAUSE_WAIT:
    - `hs_req`=0 → RELEASE (cnt=RELEASE_CYC).
    - else `paused`=1 → SETTLE (cnt=SETTLE_CYC).
    - `hs_req` drop has priority over `paused`.
  - SETTLE:
    - `paused`=0 or `hs_req`=0 → back to PAUSE_WAIT or to RELEASE respectively.
    - else cnt==0 → GRANT, `hs_gnt`<=1.
    - else cnt--.
    - Grant therefore asserts SETTLE_CYC+1 edges after `paused` is first sampled.
  - GRANT: `hs_req`=0 → RELEASE, `hs_gnt`<=0, cnt=RELEASE_CYC. `paused` dropping while granted is ignored; `pause_req` stays 1.
  - RELEASE: cnt==0 → IDLE, `pause_req`<=0; else cnt--. `hs_req` is ignored here. If still high on return to IDLE, a new cycle starts on the next edge.
- Counter widths: `$clog2(max+1)`; counts never wrap (saturate at 0).
- `cpu_rdata`/`hs_rdata` are pure pass-through of `ram_rdata`.

Optional Feature:
- Macro: HS_RAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in PAUSE_WAIT and SETTLE.
  - On reaching TIMEOUT_CYC: go to RELEASE (cnt=RELEASE_CYC), pulse `arb_timeout` for 1 cycle, never grant in that cycle.
  - The counter clears on entry to PAUSE_WAIT from IDLE.
- Not defined: no counter; PAUSE_WAIT waits indefinitely; `arb_timeout` is constant 0.

Test Plan:
- SETTLE_CYC=4, RD_LAT=1, `paused` tied 1.
  - Stimulus: `hs_req` rises sampled at edge 0.
  - Required: `pause_req`=1 after edge 0; PAUSE_WAIT samples `paused` at edge 1; `hs_gnt`=1 after edge 6.
  - Required: `hs_rd` at addr 0x8010 with RAM holding 0x5A → `hs_rvalid`=1, `hs_rdata`=0x5A exactly one cycle later.
- During GRANT: `cpu_we`=1, `cpu_addr`=0x8000, `cpu_wdata`=0x11 → `ram_we` follows `hs_we` (0); RAM 0x8000 unchanged. `hs_we`=1 with 0x22 at 0x8000 → RAM 0x8000=0x22.
- `hs_req` drops in GRANT with RELEASE_CYC=2 → `hs_gnt`=0 next edge; `pause_req` falls 3 edges after the drop; the CPU write to 0x8001 afterwards lands.
- `hs_req` pulses high for 1 cycle with `paused`=0 → PAUSE_WAIT → RELEASE → IDLE; `hs_gnt` never asserts; `pause_req` high 1+RELEASE_CYC+1 cycles.
- Reset asserted while in GRANT with `hs_we`=1 → next cycle `hs_gnt`=0, `pause_req`=0, `ram_*` follow cpu_*, `hs_rvalid`=0.
- With HS_RAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, `paused` stuck at 0, `hs_req` held → `arb_timeout` single-cycle pulse 16 cycles into PAUSE_WAIT; `pause_req` drops after RELEASE; a new request starts in IDLE next edge. Without the macro → `arb_timeout` stays 0 and the FSM holds PAUSE_WAIT for 1000 cycles.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
// Shares the game CPU work-RAM port between the Z80 and the hiscore
// save/restore engine (clk_sys domain). A hiscore request pauses the CPU,
// waits for the pause acknowledge plus a settle delay, grants the port to
// the hiscore engine, and on release drains in-flight reads before
// unpausing the CPU.
// Optional build macro: HS_RAM_ARB_TIMEOUT_EN adds a pause-acknowledge
// watchdog that aborts the request and pulses arb_timeout.
module hs_ram_arbiter #(
  parameter int AW          = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int RELEASE_CYC = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  output logic [7:0]    cpu_rdata,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  input  logic          hs_we,
  input  logic          hs_rd,
  output logic          hs_gnt,
  output logic [7:0]    hs_rdata,
  output logic          hs_rvalid,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata,
  output logic          arb_timeout
);

  // One counter serves both the settle and the release delays.
  localparam int CNT_MAX = (SETTLE_CYC > RELEASE_CYC) ? SETTLE_CYC : RELEASE_CYC;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_WAIT,
    SETTLE,
    GRANT,
    RELEASE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RD_LAT-1:0] rvld_p;

  // Delay counters stop at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - CNT_W'(1));
  endfunction

`ifdef HS_RAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // The watchdog fires on the edge that would make the wait TIMEOUT_CYC long.
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Without the watchdog the limit has no effect; this only keeps the
  // parameter referenced so both builds share one parameter list.
  if (TIMEOUT_CYC < 1) begin : g_timeout_limit_unused
  end

  assign arb_timeout = 1'b0;
`endif

  // Port mux: the select is the registered grant, so ownership changes only
  // on clock edges and a CPU write can never slip in while hiscore owns it.
  assign ram_addr  = hs_gnt ? hs_addr  : cpu_addr;
  assign ram_wdata = hs_gnt ? hs_wdata : cpu_wdata;
  assign ram_we    = hs_gnt ? hs_we    : cpu_we;

  // Read data is shared; each side qualifies it with its own ownership.
  assign cpu_rdata = ram_rdata;
  assign hs_rdata  = ram_rdata;

  // Arbitration FSM: pause handshake, settle delay, grant, drain before unpause
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pause_req <= 1'b0;
      hs_gnt    <= 1'b0;
`ifdef HS_RAM_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      arb_timeout <= 1'b0;
`endif
    end else begin
`ifdef HS_RAM_ARB_TIMEOUT_EN
      arb_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hs_req) begin
            state     <= PAUSE_WAIT;
            pause_req <= 1'b1;
`ifdef HS_RAM_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end

        PAUSE_WAIT: begin
`ifdef HS_RAM_ARB_TIMEOUT_EN
          to_cnt <= to_cnt + TO_W'(1);
`endif
          // A withdrawn request wins over a late acknowledge.
          if (!hs_req) begin
            state <= RELEASE;
            cnt   <= REL_LOAD;
          end
`ifdef HS_RAM_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state       <= RELEASE;
            cnt         <= REL_LOAD;
            arb_timeout <= 1'b1;
          end
`endif
          else if (paused) begin
            state <= SETTLE;
            cnt   <= SET_LOAD;
          end
        end

        SETTLE: begin
`ifdef HS_RAM_ARB_TIMEOUT_EN
          to_cnt <= to_cnt + TO_W'(1);
`endif
          if (!hs_req) begin
            state <= RELEASE;
            cnt   <= REL_LOAD;
          end
`ifdef HS_RAM_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state       <= RELEASE;
            cnt         <= REL_LOAD;
            arb_timeout <= 1'b1;
          end
`endif
          // Acknowledge lost while settling: restart the settle window later.
          else if (!paused) begin
            state <= PAUSE_WAIT;
          end else if (cnt == '0) begin
            state  <= GRANT;
            hs_gnt <= 1'b1;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end

        GRANT: begin
          // The CPU stays paused for the whole grant even if the pause
          // block drops its acknowledge.
          if (!hs_req) begin
            state  <= RELEASE;
            hs_gnt <= 1'b0;
            cnt    <= REL_LOAD;
          end
        end

        RELEASE: begin
          // Keep the CPU halted until the last granted read has returned.
          if (cnt == '0) begin
            state     <= IDLE;
            pause_req <= 1'b0;
          end else begin
            cnt <= sat_dec(cnt);
          end
        end

        default: begin
          state     <= IDLE;
          pause_req <= 1'b0;
          hs_gnt    <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p(RD_LAT-1): granted read strobe tracks RAM read latency
  // Read-valid shift register; ungranted strobes never enter it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_p <= '0;
    end else begin
      rvld_p <= (rvld_p << 1) | RD_LAT'(hs_gnt & hs_rd);
    end
  end

  assign hs_rvalid = rvld_p[RD_LAT-1];

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Testbench for hs_ram_arbiter: table-driven port-mux vectors, directed
// handshake sequences, and randomized traffic against a behavioural model.
module tb_hs_ram_arbiter;

  localparam int AW          = 16;
  localparam int SETTLE_CYC  = 4;
  localparam int RELEASE_CYC = 2;
  localparam int RD_LAT      = 1;
  localparam int TIMEOUT_CYC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [7:0]    cpu_rdata;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic          hs_rd;
  logic          hs_gnt;
  logic [7:0]    hs_rdata;
  logic          hs_rvalid;
  logic          pause_req;
  logic          paused;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata = 8'h00;
  logic          arb_timeout;

  always #5 clk = ~clk;

  hs_ram_arbiter #(
    .AW(AW), .SETTLE_CYC(SETTLE_CYC), .RELEASE_CYC(RELEASE_CYC),
    .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_rd(hs_rd),
    .hs_gnt(hs_gnt), .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid),
    .pause_req(pause_req), .paused(paused),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .arb_timeout(arb_timeout)
  );

  // Game work RAM: synchronous write, one-cycle registered read (old data on collision)
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    step();
    cpu_we = 1'b0;
  endtask

  task automatic acquire();
    hs_req = 1'b1; paused = 1'b1;
    for (int i = 0; i < 20 && !hs_gnt; i++) step();
    chk("acquire_gnt", 32'(hs_gnt), 32'd1);
  endtask

  task automatic release_port();
    hs_req = 1'b0; hs_we = 1'b0; hs_rd = 1'b0;
    for (int i = 0; i < 20 && pause_req; i++) step();
    chk("release_pause_req", 32'(pause_req), 32'd0);
    chk("release_gnt", 32'(hs_gnt), 32'd0);
  endtask

  // ---------------- port-mux vector table ----------------
  typedef struct {
    bit          gnt;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    bit          cpu_we;
    logic [15:0] hs_addr;
    logic [7:0]  hs_wdata;
    bit          hs_we;
    bit          hs_rd;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    bit          e_we;
    bit          e_rvalid;
    logic [7:0]  e_rdata;
    logic [15:0] m_addr;
    logic [7:0]  m_val;
  } vec_t;

  function automatic vec_t mk(bit g, logic [15:0] ca, logic [7:0] cd, bit cw,
                              logic [15:0] ha, logic [7:0] hd, bit hw, bit hr,
                              logic [15:0] ea, logic [7:0] ed, bit ew, bit erv,
                              logic [7:0] erd, logic [15:0] ma, logic [7:0] mv);
    vec_t v;
    v.gnt = g; v.cpu_addr = ca; v.cpu_wdata = cd; v.cpu_we = cw;
    v.hs_addr = ha; v.hs_wdata = hd; v.hs_we = hw; v.hs_rd = hr;
    v.e_addr = ea; v.e_wdata = ed; v.e_we = ew; v.e_rvalid = erv; v.e_rdata = erd;
    v.m_addr = ma; v.m_val = mv;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Modes: 0 CPU owns port, 1 request pending, 2 hiscore owns port, 3 draining.
  int         m_mode, m_run, m_age, m_drain_at;
  bit         m_to, m_rv;
  logic [7:0] m_rdata;
  logic [7:0] ref_mem [int];

  task automatic model_edge(input int n);
    bit g;
    logic [7:0] old;
    g = (m_mode == 2);
    m_to = 1'b0;
    old = ref_mem.exists(int'(hs_addr)) ? ref_mem[int'(hs_addr)] : 8'h00;
    if (g) begin
      if (hs_we) ref_mem[int'(hs_addr)] = hs_wdata;
    end else if (cpu_we) begin
      ref_mem[int'(cpu_addr)] = cpu_wdata;
    end
    if (reset) begin
      m_mode = 0; m_rv = 1'b0;
      return;
    end
    m_rv = g && hs_rd;
    m_rdata = old;
    case (m_mode)
      0: if (hs_req) begin m_mode = 1; m_run = 0; m_age = 0; end
      1: begin
        m_age++;
        if (!hs_req) begin
          m_mode = 3; m_drain_at = n + RELEASE_CYC + 1;
        end
`ifdef HS_RAM_ARB_TIMEOUT_EN
        else if (m_age == TIMEOUT_CYC) begin
          m_mode = 3; m_drain_at = n + RELEASE_CYC + 1; m_to = 1'b1;
        end
`endif
        else if (paused) begin
          // first paused sample plus SETTLE_CYC+1 more edges of continuous ack
          m_run++;
          if (m_run == SETTLE_CYC + 2) m_mode = 2;
        end else begin
          m_run = 0;
        end
      end
      2: if (!hs_req) begin m_mode = 3; m_drain_at = n + RELEASE_CYC + 1; end
      default: if (n >= m_drain_at) m_mode = 0;
    endcase
  endtask

  initial begin
    vec_t tv [8];
    int   cnt_a, cnt_b, cnt_c;
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    hs_req = 1'b0; hs_addr = '0; hs_wdata = '0; hs_we = 1'b0; hs_rd = 1'b0;
    paused = 1'b0;
    m_mode = 0; m_run = 0; m_age = 0; m_drain_at = 0; m_to = 1'b0; m_rv = 1'b0; m_rdata = 8'h00;

    tv[0] = mk(0, 16'h9000, 8'h77, 1, 16'h9001, 8'hAA, 0, 0, 16'h9000, 8'h77, 1, 0, 8'h00, 16'h9000, 8'h77);
    tv[1] = mk(0, 16'h9002, 8'h12, 0, 16'h9000, 8'hEE, 1, 1, 16'h9002, 8'h12, 0, 0, 8'h00, 16'h9000, 8'h77);
    tv[2] = mk(0, 16'h9003, 8'h34, 1, 16'h9000, 8'hEE, 1, 0, 16'h9003, 8'h34, 1, 0, 8'h00, 16'h9003, 8'h34);
    tv[3] = mk(1, 16'h9003, 8'h56, 1, 16'h9003, 8'h9C, 0, 1, 16'h9003, 8'h9C, 0, 1, 8'h34, 16'h9003, 8'h34);
    tv[4] = mk(1, 16'h9000, 8'h00, 1, 16'h9006, 8'hC3, 1, 0, 16'h9006, 8'hC3, 1, 0, 8'h00, 16'h9006, 8'hC3);
    tv[5] = mk(1, 16'h9001, 8'h01, 0, 16'h9006, 8'h00, 0, 1, 16'h9006, 8'h00, 0, 1, 8'hC3, 16'h9006, 8'hC3);
    tv[6] = mk(0, 16'h9007, 8'h5E, 1, 16'h9006, 8'h11, 1, 1, 16'h9007, 8'h5E, 1, 0, 8'h00, 16'h9006, 8'hC3);
    tv[7] = mk(0, 16'hFFFF, 8'hFF, 1, 16'h0000, 8'h00, 0, 0, 16'hFFFF, 8'hFF, 1, 0, 8'h00, 16'hFFFF, 8'hFF);

    // ---- reset state ----
    @(negedge clk);
    step(); step();
    chk("rst_pause_req", 32'(pause_req), 32'd0);
    chk("rst_hs_gnt", 32'(hs_gnt), 32'd0);
    chk("rst_hs_rvalid", 32'(hs_rvalid), 32'd0);
    chk("rst_arb_timeout", 32'(arb_timeout), 32'd0);
    reset = 1'b0;
    step();

    // ---- grant latency with paused tied high ----
    cpu_write(16'h8010, 8'h5A);
    cpu_write(16'h8000, 8'h33);
    paused = 1'b1; hs_req = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      chk($sformatf("lat_pause_req_e%0d", e), 32'(pause_req), 32'd1);
      chk($sformatf("lat_hs_gnt_e%0d", e), 32'(hs_gnt), 32'(e == 6));
    end

    // ---- granted read: data one cycle later ----
    hs_addr = 16'h8010; hs_rd = 1'b1;
    step();
    chk("rd_rvalid", 32'(hs_rvalid), 32'd1);
    chk("rd_hs_rdata", 32'(hs_rdata), 32'h5A);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h5A);
    hs_rd = 1'b0;
    step();
    chk("rd_rvalid_clear", 32'(hs_rvalid), 32'd0);

    // ---- CPU write blocked during grant, hiscore write lands ----
    cpu_addr = 16'h8000; cpu_wdata = 8'h11; cpu_we = 1'b1; hs_we = 1'b0;
    #1;
    chk("blk_ram_we", 32'(ram_we), 32'd0);
    step();
    chk("blk_mem_8000", 32'(mem[16'h8000]), 32'h33);
    hs_addr = 16'h8000; hs_wdata = 8'h22; hs_we = 1'b1;
    #1;
    chk("hsw_ram_we", 32'(ram_we), 32'd1);
    chk("hsw_ram_addr", 32'(ram_addr), 32'h8000);
    chk("hsw_ram_wdata", 32'(ram_wdata), 32'h22);
    step();
    chk("hsw_mem_8000", 32'(mem[16'h8000]), 32'h22);
    hs_we = 1'b0; cpu_we = 1'b0;

    // ---- release: grant drops next edge, pause_req 3 edges after drop ----
    hs_req = 1'b0;
    step();
    chk("rel_gnt_d0", 32'(hs_gnt), 32'd0);
    chk("rel_pause_d0", 32'(pause_req), 32'd1);
    step();
    chk("rel_pause_d1", 32'(pause_req), 32'd1);
    step();
    chk("rel_pause_d2", 32'(pause_req), 32'd1);
    step();
    chk("rel_pause_d3", 32'(pause_req), 32'd0);
    cpu_addr = 16'h8001; cpu_wdata = 8'h44; cpu_we = 1'b1;
    #1;
    chk("cpu_after_ram_we", 32'(ram_we), 32'd1);
    step();
    cpu_we = 1'b0;
    chk("cpu_after_mem_8001", 32'(mem[16'h8001]), 32'h44);

    // ---- one-cycle request without acknowledge ----
    paused = 1'b0; hs_req = 1'b1;
    step();
    hs_req = 1'b0;
    cnt_a = pause_req ? 1 : 0;
    cnt_b = hs_gnt ? 1 : 0;
    for (int e = 1; e < 8; e++) begin
      step();
      if (pause_req) cnt_a++;
      if (hs_gnt) cnt_b++;
    end
    chk("pulse_pause_cycles", 32'(cnt_a), 32'(1 + RELEASE_CYC + 1));
    chk("pulse_gnt_cycles", 32'(cnt_b), 32'd0);
    chk("pulse_pause_final", 32'(pause_req), 32'd0);

    // ---- reset while granted with a hiscore write pending ----
    acquire();
    hs_addr = 16'h8005; hs_wdata = 8'h99; hs_we = 1'b1; hs_rd = 1'b1;
    cpu_addr = 16'h1234; cpu_wdata = 8'h56; cpu_we = 1'b0;
    reset = 1'b1;
    step();
    chk("rstg_hs_gnt", 32'(hs_gnt), 32'd0);
    chk("rstg_pause_req", 32'(pause_req), 32'd0);
    chk("rstg_hs_rvalid", 32'(hs_rvalid), 32'd0);
    chk("rstg_ram_addr", 32'(ram_addr), 32'h1234);
    chk("rstg_ram_wdata", 32'(ram_wdata), 32'h56);
    chk("rstg_ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0; hs_req = 1'b0; hs_we = 1'b0; hs_rd = 1'b0;
    step();
    chk("rstg_idle_pause", 32'(pause_req), 32'd0);

    // ---- table-driven port-mux vectors ----
    for (int i = 0; i < 8; i++) begin
      if (tv[i].gnt && !hs_gnt) acquire();
      else if (!tv[i].gnt && hs_gnt) release_port();
      cpu_addr = tv[i].cpu_addr; cpu_wdata = tv[i].cpu_wdata; cpu_we = tv[i].cpu_we;
      hs_addr = tv[i].hs_addr; hs_wdata = tv[i].hs_wdata; hs_we = tv[i].hs_we; hs_rd = tv[i].hs_rd;
      #1;
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(tv[i].e_addr));
      chk($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(tv[i].e_wdata));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
      step();
      chk($sformatf("vec%0d_rvalid", i), 32'(hs_rvalid), 32'(tv[i].e_rvalid));
      if (tv[i].e_rvalid) chk($sformatf("vec%0d_rdata", i), 32'(hs_rdata), 32'(tv[i].e_rdata));
      chk($sformatf("vec%0d_mem", i), 32'(mem[tv[i].m_addr]), 32'(tv[i].m_val));
      cpu_we = 1'b0; hs_we = 1'b0; hs_rd = 1'b0;
    end
    if (hs_gnt) release_port();

    // ---- acknowledge never arrives ----
    paused = 1'b0; hs_req = 1'b1;
`ifdef HS_RAM_ARB_TIMEOUT_EN
    cnt_a = 0;
    for (int e = 0; e <= 20; e++) begin
      step();
      if (arb_timeout) cnt_a++;
      chk($sformatf("to_pulse_e%0d", e), 32'(arb_timeout), 32'(e == TIMEOUT_CYC));
      chk($sformatf("to_pause_e%0d", e), 32'(pause_req), 32'(e != TIMEOUT_CYC + RELEASE_CYC + 1));
    end
    chk("to_pulse_count", 32'(cnt_a), 32'd1);
`else
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int e = 0; e < 1000; e++) begin
      step();
      if (arb_timeout) cnt_a++;
      if (!pause_req) cnt_b++;
      if (hs_gnt) cnt_c++;
    end
    chk("noto_timeout_count", 32'(cnt_a), 32'd0);
    chk("noto_pause_low_count", 32'(cnt_b), 32'd0);
    chk("noto_gnt_count", 32'(cnt_c), 32'd0);
`endif
    release_port();

    // ---- randomized traffic against the reference model ----
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_mode = 0; m_rv = 1'b0; m_to = 1'b0;
    for (int a = 0; a < 16; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cpu_write(16'h8000 + 16'(a), d);
      ref_mem[int'(16'h8000) + a] = d;
    end
    for (int c = 0; c < 3000; c++) begin
      bit eg;
      if ($urandom_range(0, 19) == 0) hs_req = ~hs_req;
      if ($urandom_range(0, 9) == 0) paused = ~paused;
      reset     = ($urandom_range(0, 399) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'h8000 + 16'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      hs_we     = 1'($urandom_range(0, 1));
      hs_rd     = 1'($urandom_range(0, 1));
      hs_addr   = 16'h8000 + 16'($urandom_range(0, 15));
      hs_wdata  = 8'($urandom);
      #1;
      eg = (m_mode == 2);
      chk("rnd_ram_we", 32'(ram_we), 32'(eg ? hs_we : cpu_we));
      chk("rnd_ram_addr", 32'(ram_addr), 32'(eg ? hs_addr : cpu_addr));
      chk("rnd_ram_wdata", 32'(ram_wdata), 32'(eg ? hs_wdata : cpu_wdata));
      @(posedge clk);
      model_edge(c);
      @(negedge clk);
      chk("rnd_pause_req", 32'(pause_req), 32'(m_mode != 0));
      chk("rnd_hs_gnt", 32'(hs_gnt), 32'(m_mode == 2));
      chk("rnd_hs_rvalid", 32'(hs_rvalid), 32'(m_rv));
      chk("rnd_arb_timeout", 32'(arb_timeout), 32'(m_to));
      if (m_rv) chk("rnd_hs_rdata", 32'(hs_rdata), 32'(m_rdata));
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
